// File: rtl/rob_multi.sv
// Multi-writeback, dual-commit reorder buffer with store-commit handshake and commit-time mispredict flush.
// Alias 0 is reserved as "no dependency", so entries live in slots 1..DEPTH-1.
module rob_multi #(
    parameter int DEPTH       = 16,
    parameter int ALIAS_W     = $clog2(DEPTH),
    parameter int NUM_WB      = 2,
    parameter int DUAL_COMMIT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [31:0]               disp_pc,
    input  logic [4:0]                disp_rd,
    input  logic                      disp_is_branch,
    input  logic                      disp_is_store,
    input  logic                      disp_pred_taken,
    output logic [ALIAS_W-1:0]        disp_alias,
    input  logic [ALIAS_W-1:0]        qa_alias,
    input  logic [ALIAS_W-1:0]        qb_alias,
    output logic                      qa_ready,
    output logic                      qb_ready,
    output logic [31:0]               qa_data,
    output logic [31:0]               qb_data,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*ALIAS_W-1:0] wb_alias,
    input  logic [NUM_WB*32-1:0]      wb_data,
    input  logic [NUM_WB-1:0]         wb_taken,
    input  logic [NUM_WB*32-1:0]      wb_target,
    output logic                      st_commit_req,
    output logic [ALIAS_W-1:0]        st_commit_alias,
    input  logic                      st_done,
    output logic [1:0]                commit_valid,
    output logic [9:0]                commit_rd,
    output logic [2*ALIAS_W-1:0]      commit_alias,
    output logic [63:0]               commit_data,
    output logic                      bp_valid,
    output logic [31:0]               bp_pc,
    output logic                      bp_taken,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic [ALIAS_W-1:0]        count
);

    function automatic logic [ALIAS_W-1:0] ptr_inc(input logic [ALIAS_W-1:0] p);
        return (p == ALIAS_W'(DEPTH - 1)) ? ALIAS_W'(1) : p + ALIAS_W'(1);
    endfunction

    logic [ALIAS_W-1:0]   head_reg, tail_reg, count_reg;
    logic [ALIAS_W-1:0]   head_next, tail_next, count_next;
    logic [ALIAS_W-1:0]   head1, head2, n_commit;
    logic                 flush_reg, bp_valid_reg, bp_taken_reg;
    logic [31:0]          flush_pc_reg, bp_pc_reg;
    logic [1:0]           commit_valid_reg;
    logic [9:0]           commit_rd_reg;
    logic [2*ALIAS_W-1:0] commit_alias_reg;
    logic [63:0]          commit_data_reg;

    logic [DEPTH-1:0] ent_valid, ent_ready, ent_branch, ent_store, ent_pred, ent_taken;
    logic [31:0]      ent_pc     [DEPTH];
    logic [4:0]       ent_rd     [DEPTH];
    logic [31:0]      ent_data   [DEPTH];
    logic [31:0]      ent_target [DEPTH];

    logic empty, full, c0, c1, mispredict, disp_fire;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == ALIAS_W'(DEPTH - 1));
    assign head1      = ptr_inc(head_reg);
    assign head2      = ptr_inc(head1);
    assign disp_ready = !full && !flush_reg;

    // Slot 0 needs the LSB's st_done for a store; slot 1 only takes plain ALU ops.
    assign c0 = ent_valid[head_reg] && ent_ready[head_reg] &&
                (!ent_store[head_reg] || st_done);
    assign c1 = (DUAL_COMMIT != 0) && c0 &&
                !ent_branch[head_reg] && !ent_store[head_reg] &&
                ent_valid[head1] && ent_ready[head1] &&
                !ent_store[head1] && !ent_branch[head1];
    assign mispredict = c0 && ent_branch[head_reg] &&
                        (ent_taken[head_reg] != ent_pred[head_reg]);
    assign disp_fire  = disp_valid && disp_ready && !mispredict;

    assign st_commit_req   = !empty && ent_store[head_reg] && ent_ready[head_reg];
    assign st_commit_alias = head_reg;

    always_comb begin
        n_commit   = c1 ? ALIAS_W'(2) : (c0 ? ALIAS_W'(1) : '0);
        head_next  = c1 ? head2 : (c0 ? head1 : head_reg);
        tail_next  = disp_fire ? ptr_inc(tail_reg) : tail_reg;
        count_next = count_reg + ALIAS_W'(disp_fire) - n_commit;
        if (mispredict) begin
            head_next  = ALIAS_W'(1);
            tail_next  = ALIAS_W'(1);
            count_next = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            if (gi == 0) begin : g_null
                assign ent_valid[gi]  = 1'b0;
                assign ent_ready[gi]  = 1'b0;
                assign ent_branch[gi] = 1'b0;
                assign ent_store[gi]  = 1'b0;
                assign ent_pred[gi]   = 1'b0;
                assign ent_taken[gi]  = 1'b0;
                assign ent_pc[gi]     = '0;
                assign ent_rd[gi]     = '0;
                assign ent_data[gi]   = '0;
                assign ent_target[gi] = '0;
            end else begin : g_live
                logic        valid_reg, ready_reg, branch_reg, store_reg, pred_reg, taken_reg;
                logic [31:0] pc_reg, data_reg, target_reg;
                logic [4:0]  rd_reg;
                logic        wb_hit, wb_tk, commit_hit, disp_hit;
                logic [31:0] wb_d, wb_t;

                // Later channels overwrite earlier ones, so the highest k wins.
                always_comb begin
                    wb_hit = 1'b0;
                    wb_tk  = 1'b0;
                    wb_d   = '0;
                    wb_t   = '0;
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_valid[k] && wb_alias[k*ALIAS_W +: ALIAS_W] == ALIAS_W'(gi)) begin
                            wb_hit = 1'b1;
                            wb_tk  = wb_taken[k];
                            wb_d   = wb_data[k*32 +: 32];
                            wb_t   = wb_target[k*32 +: 32];
                        end
                    end
                end

                assign commit_hit = (c0 && head_reg == ALIAS_W'(gi)) ||
                                    (c1 && head1 == ALIAS_W'(gi));
                assign disp_hit   = disp_fire && tail_reg == ALIAS_W'(gi);

                always_ff @(posedge clk) begin
                    if (!rst) begin
                        valid_reg  <= 1'b0;
                        ready_reg  <= 1'b0;
                        branch_reg <= 1'b0;
                        store_reg  <= 1'b0;
                        pred_reg   <= 1'b0;
                        taken_reg  <= 1'b0;
                        pc_reg     <= '0;
                        rd_reg     <= '0;
                        data_reg   <= '0;
                        target_reg <= '0;
                    end else if (rdy && !flush_reg) begin
                        if (mispredict) begin
                            valid_reg <= 1'b0;
                        end else begin
                            if (wb_hit && valid_reg && !commit_hit) begin
                                ready_reg  <= 1'b1;
                                data_reg   <= wb_d;
                                taken_reg  <= wb_tk;
                                target_reg <= wb_t;
                            end
                            if (commit_hit)
                                valid_reg <= 1'b0;
                            if (disp_hit) begin
                                valid_reg  <= 1'b1;
                                ready_reg  <= 1'b0;
                                branch_reg <= disp_is_branch;
                                store_reg  <= disp_is_store;
                                pred_reg   <= disp_pred_taken;
                                taken_reg  <= 1'b0;
                                pc_reg     <= disp_pc;
                                rd_reg     <= disp_rd;
                            end
                        end
                    end
                end

                assign ent_valid[gi]  = valid_reg;
                assign ent_ready[gi]  = ready_reg;
                assign ent_branch[gi] = branch_reg;
                assign ent_store[gi]  = store_reg;
                assign ent_pred[gi]   = pred_reg;
                assign ent_taken[gi]  = taken_reg;
                assign ent_pc[gi]     = pc_reg;
                assign ent_rd[gi]     = rd_reg;
                assign ent_data[gi]   = data_reg;
                assign ent_target[gi] = target_reg;
            end
        end
    endgenerate

    logic [ALIAS_W-1:0] q_alias [2];
    logic [1:0]         q_ready;
    logic [31:0]        q_data  [2];

    assign q_alias[0] = qa_alias;
    assign q_alias[1] = qb_alias;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_lookup
            logic        hit_ready;
            logic [31:0] hit_data;

            always_comb begin
                hit_ready = ent_ready[q_alias[gi]];
                hit_data  = ent_data[q_alias[gi]];
                if (!flush_reg) begin
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_valid[k] && wb_alias[k*ALIAS_W +: ALIAS_W] == q_alias[gi]) begin
                            hit_ready = 1'b1;
                            hit_data  = wb_data[k*32 +: 32];
                        end
                    end
                end
                if (q_alias[gi] == '0) begin
                    hit_ready = 1'b1;
                    hit_data  = '0;
                end
            end

            assign q_ready[gi] = hit_ready;
            assign q_data[gi]  = hit_data;
        end
    endgenerate

    assign qa_ready = q_ready[0];
    assign qb_ready = q_ready[1];
    assign qa_data  = q_data[0];
    assign qb_data  = q_data[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_reg         <= ALIAS_W'(1);
            tail_reg         <= ALIAS_W'(1);
            count_reg        <= '0;
            flush_reg        <= 1'b0;
            flush_pc_reg     <= '0;
            bp_valid_reg     <= 1'b0;
            bp_pc_reg        <= '0;
            bp_taken_reg     <= 1'b0;
            commit_valid_reg <= '0;
            commit_rd_reg    <= '0;
            commit_alias_reg <= '0;
            commit_data_reg  <= '0;
        end else if (!rdy || flush_reg) begin
            // Pulses drop; entries and pointers stay put (already cleared by the flush edge).
            commit_valid_reg <= '0;
            bp_valid_reg     <= 1'b0;
            flush_reg        <= 1'b0;
        end else begin
            commit_valid_reg <= {c1 && (ent_rd[head1] != 5'd0),
                                 c0 && (ent_rd[head_reg] != 5'd0)};
            if (c0) begin
                commit_rd_reg[4:0]             <= ent_rd[head_reg];
                commit_alias_reg[ALIAS_W-1:0]  <= head_reg;
                commit_data_reg[31:0]          <= ent_data[head_reg];
            end
            if (c1) begin
                commit_rd_reg[9:5]                     <= ent_rd[head1];
                commit_alias_reg[2*ALIAS_W-1:ALIAS_W]  <= head1;
                commit_data_reg[63:32]                 <= ent_data[head1];
            end
            bp_valid_reg <= c0 && ent_branch[head_reg];
            if (c0 && ent_branch[head_reg]) begin
                bp_pc_reg    <= ent_pc[head_reg];
                bp_taken_reg <= ent_taken[head_reg];
            end
            flush_reg <= mispredict;
            if (mispredict)
                flush_pc_reg <= ent_taken[head_reg] ? ent_target[head_reg]
                                                    : ent_pc[head_reg] + 32'd4;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign disp_alias   = tail_reg;
    assign count        = count_reg;
    assign flush        = flush_reg;
    assign flush_pc     = flush_pc_reg;
    assign bp_valid     = bp_valid_reg;
    assign bp_pc        = bp_pc_reg;
    assign bp_taken     = bp_taken_reg;
    assign commit_valid = commit_valid_reg;
    assign commit_rd    = commit_rd_reg;
    assign commit_alias = commit_alias_reg;
    assign commit_data  = commit_data_reg;

endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised reorder buffer for the out-of-order core, replacing the single-writeback, single-commit ROB. It holds up to DEPTH-1 in-flight instructions and accepts NUM_WB result channels per cycle. It retires up to two instructions per cycle in program order and drives the store-commit handshake with the LSB. It detects branch mispredictions at commit and issues a one-cycle flush, and sits between dispatch, the CDB/ALUs/LSB, the register file and the branch predictor.

## Interface
- DEPTH, 16: entry count, power of two; alias 0 is reserved as "no dependency", so usable aliases are 1..DEPTH-1.
- ALIAS_W, $clog2(DEPTH): alias width.
- NUM_WB, 2: number of writeback channels.
- DUAL_COMMIT, 1: 1 enables the second commit slot, 0 limits commit to one per cycle.
- clk in 1: clock.
- rst in 1: synchronous, active-low reset; rst==0 at a rising edge resets the block.
- rdy in 1: global enable; when low, architectural state holds.
- disp_valid in 1, disp_ready out 1: dispatch handshake; an entry is allocated when both are high at an edge.
- disp_pc in 32, disp_rd in 5, disp_is_branch in 1, disp_is_store in 1, disp_pred_taken in 1: entry fields.
- disp_alias out ALIAS_W: alias the next allocation receives (tail).
- qa_alias, qb_alias in ALIAS_W; qa_ready, qb_ready out 1; qa_data, qb_data out 32: combinational operand lookup.
- wb_valid in NUM_WB; wb_alias in NUM_WB*ALIAS_W; wb_data in NUM_WB*32; wb_taken in NUM_WB; wb_target in NUM_WB*32: packed writeback channels, channel k at slice k.
- st_commit_req out 1, st_commit_alias out ALIAS_W: request to the LSB to perform the head store.
- st_done in 1: the LSB has completed the requested store.
- commit_valid out 2, commit_rd out 10, commit_alias out 2*ALIAS_W, commit_data out 64: registered register-file writes, slot 0 is the older.
- bp_valid out 1, bp_pc out 32, bp_taken out 1: registered predictor update.
- flush out 1, flush_pc out 32: registered one-cycle redirect.
- count out ALIAS_W: current occupancy.

## Operation
- **Pointers.** head and tail are ALIAS_W wide. Both advance by one, with DEPTH-1 wrapping to 1; 0 is never used. count is the occupancy, empty is count==0 and full is count==DEPTH-1.
- **Dispatch.** disp_ready = !full && !flush. On a dispatch edge, entry[tail] is written with ready=0, tail advances and count increments.
- **Writeback.** For every k with wb_valid[k], entry[wb_alias[k]] gets ready=1 plus data, taken and target. If two channels name the same alias, the higher k wins. Writebacks to alias 0 or to an invalid entry are ignored.
- **Lookup.**
  - Alias 0 returns ready=1, data=0.
  - Otherwise, if a wb channel matches this cycle, the lookup returns ready=1 with that channel's data (higher k wins).
  - Otherwise it returns the stored ready and data.
- **Store head.** st_commit_req = !empty && head is store && ready[head]. The store retires on the edge where st_commit_req && st_done. A store retires only from slot 0, and slot 1 never commits in that cycle.
- **Commit slot 0.** Slot 0 commits when the head is valid and ready and, for a store, st_done is high. Its commit_valid[0] is set only if rd!=0.
- **Commit slot 1.** Slot 1 commits head+1 only when all of the following hold:
  - DUAL_COMMIT=1;
  - slot 0 commits;
  - slot 0 is not a branch;
  - head+1 is valid and ready;
  - head+1 is neither a store nor a branch.
- **Commit effect.** Committing n entries advances head by n (with wrap) and reduces count by n. A dispatch in the same cycle adds 1 to count.
- **Branch commit.** A committed branch sets bp_valid=1, bp_pc=pc and bp_taken=taken.
- **Mispredict.** A mispredict is taken != pred_taken. On that edge:
  - flush goes to 1, with flush_pc = taken ? target : pc+4;
  - every entry is invalidated and head=tail=1, count=0;
  - a dispatch presented in that cycle is dropped, even if disp_ready was high.
- **Flush cycle.** While flush=1, wb inputs and dispatch are ignored. flush clears on the next edge.

## Timing
- Reset (rst==0 at an edge) clears all registered outputs and state:
  - flush=0, bp_valid=0 and commit_valid=0;
  - data/pc outputs are 0;
  - head=tail=1, so disp_alias=1, count=0 and every entry is invalid.
- Reset takes priority over rdy and over every pending event.
- When rdy==0, entries and pointers hold, and commit_valid, bp_valid and flush are cleared to 0 at the edge.
- Writeback in cycle t makes the entry ready at edge t. Commit is decided in cycle t+1, so commit_valid is high in cycle t+2.
- Dispatch and lookup of that same alias in the following cycle returns ready=0 unless a writeback bypass matches.
- Dispatch, writeback and commit in one cycle are all applied. A writeback to an entry that commits on that same edge has no effect.

## Test plan
- **Fill and empty:** with DEPTH=8, dispatch 7 entries. Expect disp_ready=0 and count=7, and aliases 1..7. The next allocation after freeing returns alias 1.
- **Dual commit:** write back aliases 1 and 2 (non-store, non-branch, rd=5 and rd=6). Expect one cycle with commit_valid=2'b11, rd=5/6 and count decreasing by 2.
- **Store handshake:** head is a ready store; hold st_done=0 for 3 cycles, then 1. Expect st_commit_req high for 4 cycles, retirement on the st_done edge, and slot 1 idle in that cycle.
- **Mispredict:** a branch with pc=0x100, pred_taken=0, taken=1, target=0x200 is followed by 3 younger entries. Expect a one-cycle flush with flush_pc=0x200, bp_valid=1, then count=0 and disp_alias=1.
- **Bypass and conflict:** wb channels 0 and 1 both target alias 3 with 0xA and 0xB, and qa_alias=3 in the same cycle. Expect qa_ready=1 with qa_data=0xB, and stored data 0xB.
- **Reset mid-run:** drive rst=0 with 5 entries live and flush pending. Expect all outputs 0, count=0 and disp_alias=1 on the next cycle.
